// File: rtl/mem_arb_pkg.sv
// Shared encodings for the icache/dcache memory arbiter.
// The optional round-robin mode is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [1:0] WS_BYTE = 2'd0;
  localparam logic [1:0] WS_HALF = 2'd1;
  localparam logic [1:0] WS_WORD = 2'd2;

  // Reserved width code 3 goes out on the bus as a plain word access.
  function automatic logic [1:0] norm_ws(input logic [1:0] ws);
    return (ws == 2'd3) ? WS_WORD : ws;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// MEM_ARB_RR_EN: alternate on ties; otherwise dcache priority with starvation override.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             icache_req_i,
  input  logic             dcache_req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  input  logic             last_i,
  output logic             grant_o,
  output logic             winner_o
);

  assign grant_o = icache_req_i | dcache_req_i;

`ifdef MEM_ARB_RR_EN
  logic unused_cnt;
  assign unused_cnt = ^starve_cnt_i;

  always_comb begin
    winner_o = OWN_D;
    if (icache_req_i && dcache_req_i) begin
      winner_o = (last_i == OWN_D) ? OWN_I : OWN_D;
    end else if (icache_req_i) begin
      winner_o = OWN_I;
    end
  end
`else
  logic unused_last;
  logic starved;
  assign unused_last = last_i;
  assign starved     = icache_req_i && (starve_cnt_i >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    winner_o = OWN_I;
    if (dcache_req_i && !starved) begin
      winner_o = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the icache and dcache requesters.
// MEM_ARB_RR_EN switches tie-breaking from dcache priority to round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_req,
  output logic [31:0] icache_data,
  output logic        icache_rdy,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic [1:0]  dcache_ws,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rdy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_ws,
  output logic        mem_wr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]       mem_ws_q, mem_ws_d;
  logic             mem_wr_q, mem_wr_d, mem_req_q, mem_req_d;
  logic [31:0]      icache_data_q, icache_data_d, dcache_rdata_q, dcache_rdata_d;
  logic             icache_rdy_q, icache_rdy_d, dcache_rdy_q, dcache_rdy_d;
  logic             grant, winner;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // owner_q doubles as the last-winner record for round-robin.
  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .icache_req_i(icache_req),
    .dcache_req_i(dcache_req),
    .starve_cnt_i(starve_cnt_q),
    .last_i      (owner_q),
    .grant_o     (grant),
    .winner_o    (winner)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (mem_rdy) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d        = owner_q;
    starve_cnt_d   = starve_cnt_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_ws_d       = mem_ws_q;
    mem_wr_d       = mem_wr_q;
    mem_req_d      = mem_req_q;
    icache_data_d  = icache_data_q;
    dcache_rdata_d = dcache_rdata_q;
    icache_rdy_d   = 1'b0;
    dcache_rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d   = winner;
          mem_req_d = 1'b1;
          if (winner == OWN_D) begin
            mem_addr_d  = dcache_addr;
            mem_wdata_d = dcache_wdata;
            mem_ws_d    = norm_ws(dcache_ws);
            mem_wr_d    = dcache_wr;
`ifndef MEM_ARB_RR_EN
            if (icache_req) starve_cnt_d = sat_inc(starve_cnt_q);
`endif
          end else begin
            mem_addr_d   = icache_addr;
            mem_wdata_d  = 32'd0;
            mem_ws_d     = WS_WORD;
            mem_wr_d     = 1'b0;
            starve_cnt_d = '0;
          end
        end
      end
      BUSY: begin
        if (mem_rdy) begin
          mem_req_d = 1'b0;
          if (owner_q == OWN_D) begin
            dcache_rdata_d = mem_rdata;
            dcache_rdy_d   = 1'b1;
          end else begin
            icache_data_d = mem_rdata;
            icache_rdy_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q        <= OWN_I;
      starve_cnt_q   <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_ws_q       <= '0;
      mem_wr_q       <= 1'b0;
      mem_req_q      <= 1'b0;
      icache_data_q  <= '0;
      dcache_rdata_q <= '0;
      icache_rdy_q   <= 1'b0;
      dcache_rdy_q   <= 1'b0;
    end else begin
      owner_q        <= owner_d;
      starve_cnt_q   <= starve_cnt_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_ws_q       <= mem_ws_d;
      mem_wr_q       <= mem_wr_d;
      mem_req_q      <= mem_req_d;
      icache_data_q  <= icache_data_d;
      dcache_rdata_q <= dcache_rdata_d;
      icache_rdy_q   <= icache_rdy_d;
      dcache_rdy_q   <= dcache_rdy_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_ws       = mem_ws_q;
  assign mem_wr       = mem_wr_q;
  assign mem_req      = mem_req_q;
  assign icache_data  = icache_data_q;
  assign icache_rdy   = icache_rdy_q;
  assign dcache_rdata = dcache_rdata_q;
  assign dcache_rdy   = dcache_rdy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/responses are queued with the stimulus.
module tb_mem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  ws;
    logic        wr;
    logic [31:0] rdata;
  } gnt_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  logic        clock, reset;
  logic [31:0] icache_addr, icache_data;
  logic        icache_req, icache_rdy;
  logic [31:0] dcache_addr, dcache_wdata, dcache_rdata;
  logic [1:0]  dcache_ws;
  logic        dcache_req, dcache_wr, dcache_rdy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_ws;
  logic        mem_wr, mem_req, mem_rdy;

  logic        auto_rdy, spur_rdy, stall;
  logic [31:0] auto_rdata, spur_rdata;
  logic [31:0] last_i, last_d;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;

  assign mem_rdy   = auto_rdy | spur_rdy;
  assign mem_rdata = spur_rdy ? spur_rdata : auto_rdata;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .icache_addr (icache_addr),
    .icache_req  (icache_req),
    .icache_data (icache_data),
    .icache_rdy  (icache_rdy),
    .dcache_addr (dcache_addr),
    .dcache_wdata(dcache_wdata),
    .dcache_ws   (dcache_ws),
    .dcache_req  (dcache_req),
    .dcache_wr   (dcache_wr),
    .dcache_rdata(dcache_rdata),
    .dcache_rdy  (dcache_rdy),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ws      (mem_ws),
    .mem_wr      (mem_wr),
    .mem_req     (mem_req),
    .mem_rdata   (mem_rdata),
    .mem_rdy     (mem_rdy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic gnt_t mk_gnt(input logic [31:0] a, input logic [31:0] wd,
                                  input logic [1:0] ws, input logic wr, input logic [31:0] rd);
    gnt_t g;
    g.addr = a; g.wdata = wd; g.ws = ws; g.wr = wr; g.rdata = rd;
    return g;
  endfunction

  function automatic rsp_t mk_rsp(input logic is_d, input logic [31:0] d);
    rsp_t r;
    r.is_d = is_d; r.data = d;
    return r;
  endfunction

  task automatic wait_rdy(input logic is_d, input string tag);
    int n = 0;
    while (!(is_d ? dcache_rdy : icache_rdy) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(n < 50), 32'd1);
  endtask

  // Memory model: checks each new request against the scoreboard and answers LAT cycles later.
  initial begin
    int   cnt;
    logic prev;
    gnt_t g;
    auto_rdy = 1'b0; auto_rdata = '0; cnt = -1; prev = 1'b0;
    g = mk_gnt('0, '0, '0, 1'b0, '0);
    forever begin
      @(negedge clock);
      auto_rdy = 1'b0;
      if (!mem_req) begin
        cnt = -1;
      end else if (!prev) begin
        check("gnt_pending", 32'(exp_gnt.size() != 0), 32'd1);
        if (exp_gnt.size() != 0) begin
          g = exp_gnt.pop_front();
          check("gnt_addr", mem_addr, g.addr);
          check("gnt_wdata", mem_wdata, g.wdata);
          check("gnt_ws", 32'(mem_ws), 32'(g.ws));
          check("gnt_wr", 32'(mem_wr), 32'(g.wr));
        end
        cnt = LAT;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !stall) begin
          auto_rdy   = 1'b1;
          auto_rdata = g.rdata;
        end
      end
      prev = mem_req;
    end
  end

  // Response monitor: every rdy pulse must match the next queued response.
  initial begin
    rsp_t r;
    logic prev_rdy;
    prev_rdy = 1'b0; last_i = '0; last_d = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        last_i = '0;
        last_d = '0;
      end
      if (icache_rdy || dcache_rdy) begin
        check("rdy_onehot", 32'(icache_rdy & dcache_rdy), 32'd0);
        check("rdy_single_cycle", 32'(prev_rdy), 32'd0);
        check("rsp_pending", 32'(exp_rsp.size() != 0), 32'd1);
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          check("rsp_owner", 32'(dcache_rdy), 32'(r.is_d));
          if (r.is_d) begin
            check("rsp_dcache_data", dcache_rdata, r.data);
            check("rsp_icache_hold", icache_data, last_i);
            last_d = r.data;
          end else begin
            check("rsp_icache_data", icache_data, r.data);
            check("rsp_dcache_hold", dcache_rdata, last_d);
            last_i = r.data;
          end
        end
      end
      prev_rdy = icache_rdy | dcache_rdy;
    end
  end

  initial begin
    int n, dn, in_;
    reset = 1'b0; stall = 1'b0;
    spur_rdy = 1'b0; spur_rdata = '0;
    icache_addr = '0; icache_req = 1'b0;
    dcache_addr = '0; dcache_wdata = '0; dcache_ws = 2'd2; dcache_req = 1'b0; dcache_wr = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_ws", 32'(mem_ws), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_rdy", 32'({icache_rdy, dcache_rdy}), 32'd0);
    check("rst_icache_data", icache_data, 32'd0);
    check("rst_dcache_rdata", dcache_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Icache-only fetch
    exp_gnt.push_back(mk_gnt(32'h0000_0100, 32'd0, 2'd2, 1'b0, 32'h0050_0093));
    exp_rsp.push_back(mk_rsp(1'b0, 32'h0050_0093));
    icache_addr = 32'h0000_0100; icache_req = 1'b1;
    @(negedge clock);
    check("fetch_grant_latency", 32'(mem_req), 32'd1);
    wait_rdy(1'b0, "fetch_rdy_timeout");
    icache_req = 1'b0;

    // Spurious mem_rdy in IDLE
    @(negedge clock);
    spur_rdy = 1'b1; spur_rdata = 32'h1234_5678;
    @(negedge clock);
    spur_rdy = 1'b0;
    check("spur_rdy", 32'({icache_rdy, dcache_rdy}), 32'd0);
    check("spur_icache_data", icache_data, 32'h0050_0093);
    check("spur_dcache_rdata", dcache_rdata, 32'd0);
    check("spur_mem_req", 32'(mem_req), 32'd0);

`ifndef MEM_ARB_RR_EN
    // Starvation: four dcache grants, then icache, then the last dcache load
    for (int i = 0; i < 4; i++)
      exp_gnt.push_back(mk_gnt(32'h3000 + 32'(i * 4), 32'd0, 2'd2, 1'b0, 32'hD000_0000 + 32'(i)));
    for (int i = 0; i < 4; i++)
      exp_rsp.push_back(mk_rsp(1'b1, 32'hD000_0000 + 32'(i)));
    exp_gnt.push_back(mk_gnt(32'h0000_0200, 32'd0, 2'd2, 1'b0, 32'h1111_0000));
    exp_rsp.push_back(mk_rsp(1'b0, 32'h1111_0000));
    exp_gnt.push_back(mk_gnt(32'h3010, 32'd0, 2'd2, 1'b0, 32'hD000_0004));
    exp_rsp.push_back(mk_rsp(1'b1, 32'hD000_0004));
    icache_addr = 32'h0000_0200; icache_req = 1'b1;
    dcache_addr = 32'h3000; dcache_wdata = 32'd0; dcache_ws = 2'd2; dcache_wr = 1'b0; dcache_req = 1'b1;
    n = 0; dn = 0; in_ = 0;
    while ((dn < 5 || in_ < 1) && n < 300) begin
      @(negedge clock);
      n++;
      if (dcache_rdy) begin
        dn++;
        if (dn < 5) dcache_addr = 32'h3000 + 32'(dn * 4);
        else dcache_req = 1'b0;
      end
      if (icache_rdy) begin
        in_++;
        icache_req = 1'b0;
      end
    end
    check("starve_dcache_count", 32'(dn), 32'd5);
    check("starve_icache_count", 32'(in_), 32'd1);

    // Simultaneous requests: dcache store first, icache in the following IDLE
    exp_gnt.push_back(mk_gnt(32'h0000_2000, 32'hDEAD_BEEF, 2'd0, 1'b1, 32'hCAFE_0001));
    exp_rsp.push_back(mk_rsp(1'b1, 32'hCAFE_0001));
    exp_gnt.push_back(mk_gnt(32'h0000_0400, 32'd0, 2'd2, 1'b0, 32'h00A0_0113));
    exp_rsp.push_back(mk_rsp(1'b0, 32'h00A0_0113));
    @(negedge clock);
    icache_addr = 32'h0000_0400; icache_req = 1'b1;
    dcache_addr = 32'h0000_2000; dcache_wdata = 32'hDEAD_BEEF; dcache_ws = 2'd0; dcache_wr = 1'b1;
    dcache_req = 1'b1;
    @(negedge clock);
    check("simul_first_wr", 32'(mem_wr), 32'd1);
    wait_rdy(1'b1, "simul_d_rdy_timeout");
    dcache_req = 1'b0; dcache_wr = 1'b0;
    @(negedge clock);
    check("simul_idle_gap", 32'(mem_req), 32'd0);
    @(negedge clock);
    check("simul_i_granted", 32'(mem_req), 32'd1);
    check("simul_i_addr", mem_addr, 32'h0000_0400);
    wait_rdy(1'b0, "simul_i_rdy_timeout");
    icache_req = 1'b0;
`else
    // Round-robin: both continuously active, grants alternate D, I, D, I
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(mk_gnt(32'h5000 + 32'(i * 4), 32'd0, 2'd2, 1'b0, 32'hD500_0000 + 32'(i)));
      exp_rsp.push_back(mk_rsp(1'b1, 32'hD500_0000 + 32'(i)));
      exp_gnt.push_back(mk_gnt(32'h6000 + 32'(i * 4), 32'd0, 2'd2, 1'b0, 32'hA600_0000 + 32'(i)));
      exp_rsp.push_back(mk_rsp(1'b0, 32'hA600_0000 + 32'(i)));
    end
    icache_addr = 32'h6000; icache_req = 1'b1;
    dcache_addr = 32'h5000; dcache_wdata = 32'd0; dcache_ws = 2'd2; dcache_wr = 1'b0; dcache_req = 1'b1;
    n = 0; dn = 0; in_ = 0;
    while ((dn < 3 || in_ < 3) && n < 300) begin
      @(negedge clock);
      n++;
      if (dcache_rdy) begin
        dn++;
        if (dn < 3) dcache_addr = 32'h5000 + 32'(dn * 4);
        else dcache_req = 1'b0;
      end
      if (icache_rdy) begin
        in_++;
        if (in_ < 3) icache_addr = 32'h6000 + 32'(in_ * 4);
        else icache_req = 1'b0;
      end
    end
    check("rr_dcache_count", 32'(dn), 32'd3);
    check("rr_icache_count", 32'(in_), 32'd3);
`endif

    // Reset mid-BUSY with memory never answering
    @(negedge clock);
    stall = 1'b1;
    exp_gnt.push_back(mk_gnt(32'h0000_0700, 32'd0, 2'd2, 1'b0, 32'h7777_7777));
    icache_addr = 32'h0000_0700; icache_req = 1'b1;
    @(negedge clock);
    check("midrst_busy_req", 32'(mem_req), 32'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_async_req", 32'(mem_req), 32'd0);
    check("midrst_async_addr", mem_addr, 32'd0);
    check("midrst_rdy", 32'({icache_rdy, dcache_rdy}), 32'd0);
    check("midrst_icache_data", icache_data, 32'd0);
    icache_req = 1'b0;
    @(negedge clock);
    reset = 1'b1; stall = 1'b0;
    @(negedge clock);
    exp_gnt.push_back(mk_gnt(32'h0000_0800, 32'd0, 2'd2, 1'b0, 32'h0BAD_F00D));
    exp_rsp.push_back(mk_rsp(1'b0, 32'h0BAD_F00D));
    icache_addr = 32'h0000_0800; icache_req = 1'b1;
    @(negedge clock);
    check("postrst_grant_latency", 32'(mem_req), 32'd1);
    wait_rdy(1'b0, "postrst_rdy_timeout");
    icache_req = 1'b0;

    repeat (4) @(negedge clock);
    check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
